// File: rtl/scancode_decoder_pkg.sv
// Shared types and tables for the PS/2 scan-code decoder: prefix FSM states,
// prefix bytes, codes ignored outside a prefix, and the tracked-key map.
package scancode_decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam int EVT_W       = 10;
    localparam int NUM_DISCARD = 7;
    localparam int NUM_TRACKED = 8;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic [2:0] idx;
    } track_t;

    // Keyboard housekeeping bytes (BAT result, echo, ACK, resend, error, pause lead-in)
    localparam logic [7:0] DISCARD_CODES [NUM_DISCARD] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1
    };

    localparam track_t TRACKED_KEYS [NUM_TRACKED] = '{
        '{code: 8'h75, ext: 1'b1, idx: 3'd0},
        '{code: 8'h72, ext: 1'b1, idx: 3'd1},
        '{code: 8'h6B, ext: 1'b1, idx: 3'd2},
        '{code: 8'h74, ext: 1'b1, idx: 3'd3},
        '{code: 8'h29, ext: 1'b0, idx: 3'd4},
        '{code: 8'h5A, ext: 1'b0, idx: 3'd5},
        '{code: 8'h76, ext: 1'b0, idx: 3'd6},
        '{code: 8'h1D, ext: 1'b0, idx: 3'd7}
    };

    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (b == DISCARD_CODES[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] held_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            if (code == TRACKED_KEYS[i].code && ext == TRACKED_KEYS[i].ext)
                m[TRACKED_KEYS[i].idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/scancode_decoder_if.sv
// Push/pop bundle between the decoder and its event FIFO.
interface scancode_decoder_if #(
    parameter int W = 10
);
    logic         push;
    logic [W-1:0] wdata;
    logic         pop;
    logic [W-1:0] rdata;
    logic         full;
    logic         empty;

    modport master (output push, wdata, pop, input rdata, full, empty);
    modport slave  (input push, wdata, pop, output rdata, full, empty);
endinterface

// File: rtl/scancode_decoder_fifo.sv
// Event FIFO: first-word-fall-through, accepts push on full when a pop happens
// in the same cycle; otherwise a push on full is ignored.
module event_fifo
    import scancode_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    scancode_decoder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = bus.pop & ~w_empty;
    assign w_do_push = bus.push & (~w_full | w_do_pop);

    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.rdata = r_mem[r_rd];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            if (w_do_pop)
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the read side is gated by empty upstream.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= bus.wdata;
    end

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext, brk, code} events,
// queues them in a FIFO and tracks a live bitmap of selected keys.
module scancode_decoder
    import scancode_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_finish,
    input  logic       i_ready,
    input  logic       i_clr_ovf,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic       o_ext,
    output logic       o_break,
    output logic [7:0] o_held,
    output logic       o_overflow
);
    state_t     r_state;
    logic [7:0] r_held;
    logic       r_overflow;

    event_t     w_evt;
    event_t     w_head;
    logic       w_evt_vld;
    logic [7:0] w_mask;
    logic       w_valid;
    logic       w_pop;
    logic       w_drop;

    scancode_decoder_if #(.W(EVT_W)) w_fifo_if ();

    always_comb begin
        w_evt.ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_evt.brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
        w_evt.code = i_data;
        w_evt_vld  = 1'b0;
        if (i_finish) begin
            case (r_state)
                S_IDLE:  w_evt_vld = !(i_data == PFX_EXT || i_data == PFX_BRK || is_discard(i_data));
                S_EXT:   w_evt_vld = !(i_data == PFX_EXT || i_data == PFX_BRK);
                default: w_evt_vld = (i_data != PFX_BRK);
            endcase
        end
    end

    assign w_mask  = held_mask(i_data, w_evt.ext);
    assign w_valid = ~w_fifo_if.empty;
    assign w_pop   = w_valid & i_ready;
    assign w_drop  = w_evt_vld & w_fifo_if.full & ~w_pop;

    assign w_fifo_if.push  = w_evt_vld;
    assign w_fifo_if.wdata = w_evt;
    assign w_fifo_if.pop   = w_pop;

    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (w_fifo_if.slave)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_held     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (i_finish) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_data == PFX_EXT)      r_state <= S_EXT;
                        else if (i_data == PFX_BRK) r_state <= S_BRK;
                    end
                    S_EXT: begin
                        if (i_data == PFX_BRK)      r_state <= S_EXT_BRK;
                        else if (i_data != PFX_EXT) r_state <= S_IDLE;
                    end
                    default: begin
                        if (i_data != PFX_BRK)      r_state <= S_IDLE;
                    end
                endcase
            end
            // Key bitmap follows decoded events even when the FIFO drops them.
            if (w_evt_vld)
                r_held <= w_evt.brk ? (r_held & ~w_mask) : (r_held | w_mask);
            if (w_drop)
                r_overflow <= 1'b1;
            else if (i_clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    assign w_head     = w_valid ? event_t'(w_fifo_if.rdata) : '0;
    assign o_valid    = w_valid;
    assign o_code     = w_head.code;
    assign o_ext      = w_head.ext;
    assign o_break    = w_head.brk;
    assign o_held     = r_held;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder with FIFO_DEPTH = 4.
module tb_scancode_decoder;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_finish;
    logic       i_ready;
    logic       i_clr_ovf;
    logic       o_valid;
    logic [7:0] o_code;
    logic       o_ext;
    logic       o_break;
    logic [7:0] o_held;
    logic       o_overflow;

    int n_checks = 0;
    int n_err    = 0;

    always #5 i_clk = ~i_clk;

    scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_finish   (i_finish),
        .i_ready    (i_ready),
        .i_clr_ovf  (i_clr_ovf),
        .o_valid    (o_valid),
        .o_code     (o_code),
        .o_ext      (o_ext),
        .o_break    (o_break),
        .o_held     (o_held),
        .o_overflow (o_overflow)
    );

    // Consumer-side view of the event stream.
    scancode_decoder_if #(.W(10)) mon ();
    assign mon.push  = i_finish;
    assign mon.wdata = {2'b00, i_data};
    assign mon.pop   = o_valid & i_ready;
    assign mon.rdata = {o_ext, o_break, o_code};
    assign mon.full  = o_overflow;
    assign mon.empty = ~o_valid;

    wire [10:0] head = {o_valid, o_ext, o_break, o_code};

    task automatic send_byte(input logic [7:0] b);
        i_data   = b;
        i_finish = 1'b1;
        @(posedge i_clk);
        #1;
        i_finish = 1'b0;
    endtask

    task automatic pop_head();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if ({head, o_held, o_overflow} !== {11'h000, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got head=%h held=%h ovf=%b exp 000/00/0", head, o_held, o_overflow);
        end
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_make();
        send_byte(8'h1C);
        n_checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
            n_err++; $display("FAIL make_head got=%h exp=%h", head, {3'b100, 8'h1C});
        end
        n_checks++;
        if (o_held !== 8'h00) begin
            n_err++; $display("FAIL make_held got=%h exp=00", o_held);
        end
        pop_head();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL make_pop_empty got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0); send_byte(8'h75);
        n_checks++;
        if ({head, o_held} !== {3'b110, 8'h75, 8'h01}) begin
            n_err++; $display("FAIL ext_make got=%h held=%h exp=675/01", head, o_held);
        end
        pop_head();
        send_byte(8'hE0); send_byte(8'hF0);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL prefix_no_event got=%b exp=0", o_valid);
        end
        send_byte(8'h75);
        n_checks++;
        if ({head, o_held} !== {3'b111, 8'h75, 8'h00}) begin
            n_err++; $display("FAIL ext_break got=%h held=%h exp=775/00", head, o_held);
        end
        pop_head();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL ext_break_single got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [4];
        exp_codes = '{8'h1D, 8'h29, 8'h5A, 8'h76};
        for (int i = 0; i < 4; i++) send_byte(exp_codes[i]);
        n_checks++;
        if ({o_overflow, o_held, head} !== {1'b0, 8'hF0, 3'b100, 8'h1D}) begin
            n_err++; $display("FAIL fill4 got ovf=%b held=%h head=%h exp 0/F0/41D", o_overflow, o_held, head);
        end
        send_byte(8'hF0); send_byte(8'h1D);
        n_checks++;
        if ({o_overflow, o_held} !== {1'b1, 8'h70}) begin
            n_err++; $display("FAIL drop5 got ovf=%b held=%h exp 1/70", o_overflow, o_held);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (head !== {3'b100, exp_codes[i]}) begin
                n_err++; $display("FAIL ovf_order%0d got=%h exp=%h", i, head, {3'b100, exp_codes[i]});
            end
            pop_head();
        end
        n_checks++;
        if ({o_valid, o_overflow} !== 2'b01) begin
            n_err++; $display("FAIL ovf_drained got valid=%b ovf=%b exp 0/1", o_valid, o_overflow);
        end
        i_clr_ovf = 1'b1; @(posedge i_clk); #1; i_clr_ovf = 1'b0;
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear got=%b exp=0", o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        i_data = 8'h05; i_finish = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_finish = 1'b0; i_ready = 1'b0;
        n_checks++;
        if ({o_overflow, head} !== {1'b0, 3'b100, 8'h02}) begin
            n_err++; $display("FAIL full_pushpop got ovf=%b head=%h exp 0/402", o_overflow, head);
        end
        send_byte(8'h06);
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_err++; $display("FAIL still_full got=%b exp=1", o_overflow);
        end
        i_clr_ovf = 1'b1; send_byte(8'h07); i_clr_ovf = 1'b0;
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_err++; $display("FAIL drop_beats_clear got=%b exp=1", o_overflow);
        end
        i_clr_ovf = 1'b1; @(posedge i_clk); #1; i_clr_ovf = 1'b0;
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_err++; $display("FAIL clear2 got=%b exp=0", o_overflow);
        end
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (head !== {3'b100, 8'(i)}) begin
                n_err++; $display("FAIL wrap_order%0d got=%h exp=%h", i, head, {3'b100, 8'(i)});
            end
            pop_head();
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_empty got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_discard_reset();
        send_byte(8'h5A);
        send_byte(8'hAA);
        n_checks++;
        if ({head, o_held} !== {3'b100, 8'h5A, 8'h70}) begin
            n_err++; $display("FAIL discard_aa got head=%h held=%h exp 45A/70", head, o_held);
        end
        send_byte(8'hE0);
        i_rst = 1'b1;
        #2;
        n_checks++;
        if ({head, o_held, o_overflow} !== {11'h000, 8'h00, 1'b0}) begin
            n_err++; $display("FAIL async_reset got head=%h held=%h ovf=%b exp 000/00/0", head, o_held, o_overflow);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle got=%b exp=0", o_valid);
        end
        send_byte(8'h29);
        n_checks++;
        if ({head, o_held} !== {3'b100, 8'h29, 8'h10}) begin
            n_err++; $display("FAIL reset_prefix_lost got head=%h held=%h exp 429/10", head, o_held);
        end
        pop_head();
    endtask

    task automatic test_prefix_discard();
        send_byte(8'hE0); send_byte(8'hAA);
        n_checks++;
        if (head !== {3'b110, 8'hAA}) begin
            n_err++; $display("FAIL ext_aa got=%h exp=6AA", head);
        end
        pop_head();
        send_byte(8'hF0); send_byte(8'hF0); send_byte(8'hFF);
        n_checks++;
        if (head !== {3'b101, 8'hFF}) begin
            n_err++; $display("FAIL dup_brk_ff got=%h exp=5FF", head);
        end
        pop_head();
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
        n_checks++;
        if ({head, o_held} !== {3'b110, 8'h6B, 8'h14}) begin
            n_err++; $display("FAIL dup_ext_left got head=%h held=%h exp 66B/14", head, o_held);
        end
        pop_head();
        send_byte(8'h29);
        n_checks++;
        if ({head, o_held} !== {3'b100, 8'h29, 8'h14}) begin
            n_err++; $display("FAIL repeat_make got head=%h held=%h exp 429/14", head, o_held);
        end
        pop_head();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL final_empty got=%b exp=0", o_valid);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_data = 8'h00; i_finish = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0;
        test_reset();
        test_make();
        test_ext_break();
        test_overflow();
        test_full_push_pop();
        test_discard_reset();
        test_prefix_discard();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
